morse_rx_decoder: RTL and testbench
===================================

# morse_rx_decoder

Parametrised Morse receive front end for the `tt_um_morse` design. It samples a raw key line, debounces it, and times marks and spaces in units of a runtime-programmable dot length. It classifies each mark as a dot or dash, assembles the elements into characters, and delivers character codes and word-gap markers through a small FIFO with a valid/ready handshake. It replaces the fixed-timing receive path of `rec_fsm` with configurable speed, element depth and buffering, and adds overflow reporting.

## Interface
- `CNT_W`, 16: width of the duration counter and of `unit_len`.
- `MAX_SYM`, 6: maximum elements per character. Width of `code_bits`.
- `DEPTH`, 4: FIFO entries. Must be a power of 2, at least 2.
- `DEBOUNCE`, 4: stable cycles required before the debounced key changes. Minimum 1.

Ports:
- `clk`  in  1  system clock.
- `rst_n`  in  1  asynchronous, active-low reset.
- `ena`  in  1  when low, the synchroniser, debouncer, counter and FSM hold state. The FIFO read side keeps operating.
- `unit_len`  in  CNT_W  dot unit in clock cycles. The value 0 is treated as 1.
- `key_in`  in  1  raw key, 1 = pressed. Asynchronous to `clk`.
- `key_state`  out  1  debounced key.
- `code_valid`  out  1  FIFO non-empty.
- `code_ready`  in  1  consumer accepts the head entry.
- `code_len`  out  $clog2(MAX_SYM+1)  element count of the head entry. 0 means a word-gap entry.
- `code_bits`  out  MAX_SYM  bit i = element i (first element in bit 0); 1 = dash. Unused bits are 0.
- `code_ovf`  out  1  head character had more than MAX_SYM elements.
- `word_gap`  out  1  head entry is a word-gap marker.
- `fifo_ovf`  out  1  sticky: an entry was dropped because the FIFO was full. Cleared only by reset.

## Operation
- Input conditioning:
  - `key_in` passes through a 2-flop synchroniser giving `key_s`.
  - A debounce counter increments while `key_s != key_state` and clears when they match.
  - When the counter reaches DEBOUNCE, `key_state` toggles and the counter clears.
- Duration counter `dur`:
  - Counts the cycles `key_state` has held its current value, so it equals 1 in the first cycle after a toggle.
  - Saturates at 2^CNT_W-1.
- Thresholds use U = max(unit_len, 1), with widened arithmetic (CNT_W+3 bits):
  - dash threshold D = 2U
  - letter threshold L = 2U
  - word threshold W = 5U
- FSM states:
  - IDLE: key up, no character open. On press → MARK.
  - MARK: key down. On release: if the element count is below MAX_SYM, set bit[count] = (dur ≥ D) and increment count; otherwise set the ovf flag. Then → SPACE.
  - SPACE: key up, character open. Press with dur < L → MARK (same character). dur == L → push {count, bits, ovf, word=0}, clear count/bits/ovf, → GAP.
  - GAP: character committed. Press → MARK (new character). dur == W → push {0, 0, 0, word=1}, → IDLE.
- Long presses saturate `dur` and are still classified as dashes.
- A press in IDLE never produces a word entry; only the first word gap after a character does.
- FIFO (first-word fall-through):
  - Outputs always show the head entry; all outputs are 0 when empty.
  - A pop occurs when `code_valid && code_ready`.
  - A push while full with no pop drops the new entry and sets `fifo_ovf`.
  - A simultaneous push and pop while full is accepted.
  - A push into an empty FIFO is visible the next cycle.
- `ena` low in any state freezes the FSM, `dur`, the debouncer and the synchroniser. Timing resumes unchanged when `ena` returns high.

## Timing
- Reset: all outputs are 0, the FSM is IDLE, the FIFO is empty, and `key_state` = 0. An asserted reset mid-character discards the partial character with no push.
- `key_in` edge to `key_state` edge: 2 + DEBOUNCE cycles. Pulses shorter than DEBOUNCE cycles at `key_s` are ignored.
- Element classification takes effect on the clock edge at which `key_state` falls. There is no extra latency.
- Character push happens on the edge where `dur` == L in SPACE; `code_valid` rises the next cycle when the FIFO was empty.
- Word entry is pushed on the edge where `dur` == W in GAP, i.e. 3U cycles after the character push.
- Throughput is one pop per cycle. At most one push can occur per cycle.

## Test plan
- Reset: hold `rst_n`=0 with `key_in` toggling → all outputs 0. Release → `code_valid`=0 and `key_state` follows `key_in` after 2+DEBOUNCE cycles.
- Letter A (unit_len=4, DEBOUNCE=2, `code_ready`=0): press 4, gap 4, press 12, release, idle 8 → `code_valid`=1, `code_len`=2, `code_bits`=6'b000010, `word_gap`=0.
- Word gap: continue idle ≥ 12 more cycles, then pop → second entry `code_len`=0, `word_gap`=1. A further 100 idle cycles produce no more entries.
- Element overflow: 7 dots in one character → `code_len`=6, `code_bits`=0, `code_ovf`=1.
- FIFO full: `code_ready`=0, send 5 characters (E,T,E,T,E) separated by 3U gaps → `fifo_ovf`=1. Drain → bits 0,1,0,1 in order, then `code_valid`=0.
- Glitch/ena: a 1-cycle `key_in` pulse gives no `key_state` change and no entry. `ena`=0 during a mark of 6 cycles for 50 cycles extends nothing, and the mark is still classified as a dot.

Source files
------------

// File: rtl/morse_rx_decoder.sv
// Morse receive front end: synchronise and debounce the key, time marks/spaces
// against a programmable dot unit, assemble characters and queue them in a FWFT FIFO.
module morse_rx_decoder #(
    parameter int CNT_W    = 16,
    parameter int MAX_SYM  = 6,
    parameter int DEPTH    = 4,
    parameter int DEBOUNCE = 4
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         ena,
    input  logic [CNT_W-1:0]             unit_len,
    input  logic                         key_in,
    output logic                         key_state,
    output logic                         code_valid,
    input  logic                         code_ready,
    output logic [$clog2(MAX_SYM+1)-1:0] code_len,
    output logic [MAX_SYM-1:0]           code_bits,
    output logic                         code_ovf,
    output logic                         word_gap,
    output logic                         fifo_ovf
);
    localparam int LW  = $clog2(MAX_SYM + 1);
    localparam int AW  = $clog2(DEPTH);
    localparam int CW  = AW + 1;
    localparam int DBW = $clog2(DEBOUNCE + 1);
    localparam int TW  = CNT_W + 3;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_MARK  = 2'd1;
    localparam logic [1:0] S_SPACE = 2'd2;
    localparam logic [1:0] S_GAP   = 2'd3;

    logic               r_sync1, r_sync2;
    logic               r_key_state;
    logic [DBW-1:0]     r_db_cnt;
    logic [CNT_W-1:0]   r_dur;
    logic [1:0]         r_state;
    logic [LW-1:0]      r_cnt;
    logic [MAX_SYM-1:0] r_bits;
    logic               r_ovf;

    logic               w_db_hit, w_rise, w_fall;
    logic [CNT_W-1:0]   w_u;
    logic [TW-1:0]      w_u_ext, w_dur_ext, w_thr_l, w_thr_w;
    logic               w_is_dash, w_at_l, w_at_w;
    logic [MAX_SYM-1:0] w_one;

    logic [1:0]         w_state_next;
    logic [LW-1:0]      w_cnt_next;
    logic [MAX_SYM-1:0] w_bits_next;
    logic               w_ovf_next;
    logic               w_push, w_push_en;
    logic [LW-1:0]      w_push_len;
    logic [MAX_SYM-1:0] w_push_bits;
    logic               w_push_ovf, w_push_word;

    // Two-flop synchroniser; frozen with the rest of the timing path when ena is low.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
        end else if (ena) begin
            r_sync1 <= key_in;
            r_sync2 <= r_sync1;
        end
    end

    assign w_db_hit = (r_sync2 != r_key_state) && (r_db_cnt == DBW'(DEBOUNCE - 1));
    assign w_rise   = w_db_hit & ~r_key_state;
    assign w_fall   = w_db_hit & r_key_state;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_key_state <= 1'b0;
            r_db_cnt    <= '0;
            r_dur       <= '0;
        end else if (ena) begin
            if (r_sync2 != r_key_state) begin
                if (w_db_hit) begin
                    r_key_state <= ~r_key_state;
                    r_db_cnt    <= '0;
                end else begin
                    r_db_cnt <= r_db_cnt + DBW'(1);
                end
            end else begin
                r_db_cnt <= '0;
            end
            // dur restarts at 1 on the toggle edge so it counts the new level's cycles
            if (w_db_hit)
                r_dur <= CNT_W'(1);
            else if (r_dur != {CNT_W{1'b1}})
                r_dur <= r_dur + CNT_W'(1);
        end
    end

    assign w_u       = (unit_len == '0) ? CNT_W'(1) : unit_len;
    assign w_u_ext   = {3'b000, w_u};
    assign w_dur_ext = {3'b000, r_dur};
    assign w_thr_l   = w_u_ext << 1;
    assign w_thr_w   = (w_u_ext << 2) + w_u_ext;
    assign w_is_dash = (w_dur_ext >= w_thr_l);
    assign w_at_l    = (w_dur_ext == w_thr_l);
    assign w_at_w    = (w_dur_ext == w_thr_w);
    assign w_one     = {{(MAX_SYM-1){1'b0}}, 1'b1};

    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        w_bits_next  = r_bits;
        w_ovf_next   = r_ovf;
        w_push       = 1'b0;
        w_push_len   = r_cnt;
        w_push_bits  = r_bits;
        w_push_ovf   = r_ovf;
        w_push_word  = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_rise) w_state_next = S_MARK;
            end
            S_MARK: begin
                if (w_fall) begin
                    if (r_cnt < LW'(MAX_SYM)) begin
                        w_bits_next = r_bits | (w_is_dash ? (w_one << r_cnt) : '0);
                        w_cnt_next  = r_cnt + LW'(1);
                    end else begin
                        w_ovf_next = 1'b1;
                    end
                    w_state_next = S_SPACE;
                end
            end
            S_SPACE: begin
                if (w_at_l) begin
                    w_push       = 1'b1;
                    w_cnt_next   = '0;
                    w_bits_next  = '0;
                    w_ovf_next   = 1'b0;
                    w_state_next = w_rise ? S_MARK : S_GAP;
                end else if (w_rise) begin
                    w_state_next = S_MARK;
                end
            end
            S_GAP: begin
                if (w_at_w) begin
                    w_push       = 1'b1;
                    w_push_len   = '0;
                    w_push_bits  = '0;
                    w_push_ovf   = 1'b0;
                    w_push_word  = 1'b1;
                    w_state_next = w_rise ? S_MARK : S_IDLE;
                end else if (w_rise) begin
                    w_state_next = S_MARK;
                end
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    assign w_push_en = w_push & ena;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_bits  <= '0;
            r_ovf   <= 1'b0;
        end else if (ena) begin
            r_state <= w_state_next;
            r_cnt   <= w_cnt_next;
            r_bits  <= w_bits_next;
            r_ovf   <= w_ovf_next;
        end
    end

    // First-word fall-through FIFO; the read side ignores ena.
    logic [LW-1:0]      r_mem_len  [DEPTH];
    logic [MAX_SYM-1:0] r_mem_bits [DEPTH];
    logic               r_mem_ovf  [DEPTH];
    logic               r_mem_word [DEPTH];
    logic [AW-1:0]      r_wr_ptr, r_rd_ptr;
    logic [CW-1:0]      r_count;
    logic               r_fifo_ovf;
    logic               w_empty, w_full, w_pop, w_wr;

    assign w_empty = (r_count == '0);
    assign w_full  = (r_count == CW'(DEPTH));
    assign w_pop   = ~w_empty & code_ready;
    assign w_wr    = w_push_en & (~w_full | w_pop);

    always_ff @(posedge clk) begin
        if (w_wr) begin
            r_mem_len[r_wr_ptr]  <= w_push_len;
            r_mem_bits[r_wr_ptr] <= w_push_bits;
            r_mem_ovf[r_wr_ptr]  <= w_push_ovf;
            r_mem_word[r_wr_ptr] <= w_push_word;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_fifo_ovf <= 1'b0;
        end else begin
            if (w_wr)  r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_pop) r_rd_ptr <= r_rd_ptr + AW'(1);
            case ({w_wr, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
            if (w_push_en && w_full && !w_pop) r_fifo_ovf <= 1'b1;
        end
    end

    assign key_state  = r_key_state;
    assign code_valid = ~w_empty;
    assign code_len   = w_empty ? '0 : r_mem_len[r_rd_ptr];
    assign code_bits  = w_empty ? '0 : r_mem_bits[r_rd_ptr];
    assign code_ovf   = w_empty ? 1'b0 : r_mem_ovf[r_rd_ptr];
    assign word_gap   = w_empty ? 1'b0 : r_mem_word[r_rd_ptr];
    assign fifo_ovf   = r_fifo_ovf;
endmodule

// File: tb/tb_morse_rx_decoder.sv
// Scoreboard bench for morse_rx_decoder: stimulus queues expected entries,
// a negedge monitor pops and compares each entry the DUT hands over.
module tb_morse_rx_decoder;
    localparam int CNT_W    = 16;
    localparam int MAX_SYM  = 6;
    localparam int DEPTH    = 4;
    localparam int DEBOUNCE = 2;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              ena = 1'b1;
    logic [CNT_W-1:0]  unit_len = 16'd4;
    logic              key_in = 1'b0;
    logic              code_ready = 1'b0;
    logic              key_state, code_valid, code_ovf, word_gap, fifo_ovf;
    logic [2:0]        code_len;
    logic [MAX_SYM-1:0] code_bits;

    typedef struct packed {
        logic [2:0] len;
        logic [5:0] bits;
        logic       ovf;
        logic       word;
    } entry_t;

    entry_t exp_q[$];
    int total = 0;
    int bad   = 0;

    morse_rx_decoder #(
        .CNT_W(CNT_W), .MAX_SYM(MAX_SYM), .DEPTH(DEPTH), .DEBOUNCE(DEBOUNCE)
    ) dut (
        .clk(clk), .rst_n(rst_n), .ena(ena), .unit_len(unit_len), .key_in(key_in),
        .key_state(key_state), .code_valid(code_valid), .code_ready(code_ready),
        .code_len(code_len), .code_bits(code_bits), .code_ovf(code_ovf),
        .word_gap(word_gap), .fifo_ovf(fifo_ovf)
    );

    always #5 clk = ~clk;

    function automatic entry_t mk(logic [2:0] l, logic [5:0] b, logic o, logic w);
        entry_t e;
        e.len = l; e.bits = b; e.ovf = o; e.word = w;
        return e;
    endfunction

    task automatic check(string name, logic [31:0] act, logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
        end
    endtask

    task automatic tick(int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic mark(int n);
        key_in = 1'b1;
        tick(n);
        key_in = 1'b0;
    endtask

    // Monitor: one line per popped entry, compared against the scoreboard head.
    always @(negedge clk) begin
        entry_t e;
        if (rst_n && code_valid && code_ready) begin
            $display("pop: len=%0d bits=%b ovf=%0d word=%0d", code_len, code_bits, code_ovf, word_gap);
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_entry: got len=%0d bits=%b word=%0d, expected none",
                         code_len, code_bits, word_gap);
            end else begin
                e = exp_q.pop_front();
                check("entry", 32'({code_len, code_bits, code_ovf, word_gap}), 32'(e));
            end
        end
    end

    initial begin
        int n;
        logic seen;

        // Reset with the key toggling: every output stays low.
        for (int i = 0; i < 6; i++) begin
            key_in = ~key_in;
            tick(1);
            check("reset_outputs", 32'({key_state, code_valid, code_len, code_bits,
                                        code_ovf, word_gap, fifo_ovf}), 32'(0));
        end
        key_in = 1'b0;
        tick(2);
        rst_n = 1'b1;
        tick(1);
        check("post_reset_valid", 32'(code_valid), 32'(0));
        check("post_reset_key_state", 32'(key_state), 32'(0));

        // key_state follows key_in after 2+DEBOUNCE cycles; the 4-cycle press is an E.
        code_ready = 1'b1;
        exp_q.push_back(mk(3'd1, 6'b000000, 1'b0, 1'b0));
        exp_q.push_back(mk(3'd0, 6'b000000, 1'b0, 1'b1));
        key_in = 1'b1;
        tick(3);
        check("key_latency_early", 32'(key_state), 32'(0));
        tick(1);
        check("key_latency", 32'(key_state), 32'(1));
        key_in = 1'b0;
        tick(40);

        // Letter A held in the FIFO, then the word gap behind it.
        code_ready = 1'b0;
        exp_q.push_back(mk(3'd2, 6'b000010, 1'b0, 1'b0));
        exp_q.push_back(mk(3'd0, 6'b000000, 1'b0, 1'b1));
        mark(4);
        tick(4);
        mark(12);
        n = 0;
        while (!code_valid && n < 60) begin
            tick(1);
            n++;
        end
        check("A_valid", 32'(code_valid), 32'(1));
        check("A_len", 32'(code_len), 32'(2));
        check("A_bits", 32'(code_bits), 32'(6'b000010));
        check("A_word_gap", 32'(word_gap), 32'(0));
        check("A_ovf", 32'(code_ovf), 32'(0));
        tick(40);
        check("A_head_held", 32'(code_len), 32'(2));
        code_ready = 1'b1;
        tick(100);

        // Seven dots overflow a six-element character.
        exp_q.push_back(mk(3'd6, 6'b000000, 1'b1, 1'b0));
        exp_q.push_back(mk(3'd0, 6'b000000, 1'b0, 1'b1));
        repeat (7) begin
            mark(4);
            tick(4);
        end
        tick(40);

        // E,T,E,T,E with 3U gaps into a stalled 4-deep FIFO: the fifth is dropped.
        code_ready = 1'b0;
        mark(4);  tick(12);
        mark(12); tick(12);
        mark(4);  tick(12);
        mark(12); tick(12);
        mark(4);
        tick(40);
        check("fifo_ovf_set", 32'(fifo_ovf), 32'(1));
        exp_q.push_back(mk(3'd1, 6'b000000, 1'b0, 1'b0));
        exp_q.push_back(mk(3'd1, 6'b000001, 1'b0, 1'b0));
        exp_q.push_back(mk(3'd1, 6'b000000, 1'b0, 1'b0));
        exp_q.push_back(mk(3'd1, 6'b000001, 1'b0, 1'b0));
        code_ready = 1'b1;
        tick(6);
        check("drained_valid", 32'(code_valid), 32'(0));
        check("fifo_ovf_sticky", 32'(fifo_ovf), 32'(1));

        // A single-cycle glitch must not move key_state.
        key_in = 1'b1;
        tick(1);
        key_in = 1'b0;
        seen = 1'b0;
        repeat (12) begin
            tick(1);
            if (key_state) seen = 1'b1;
        end
        check("glitch_key_state", 32'(seen), 32'(0));
        tick(30);

        // A 6-cycle mark with a 50-cycle ena freeze in the middle is still a dot.
        exp_q.push_back(mk(3'd1, 6'b000000, 1'b0, 1'b0));
        exp_q.push_back(mk(3'd0, 6'b000000, 1'b0, 1'b1));
        key_in = 1'b1;
        tick(5);
        check("ena_key_down", 32'(key_state), 32'(1));
        ena = 1'b0;
        tick(50);
        ena = 1'b1;
        tick(1);
        key_in = 1'b0;
        tick(40);

        // Reset mid-character discards it and clears the sticky overflow.
        mark(4);
        tick(6);
        rst_n = 1'b0;
        tick(1);
        check("midchar_reset_outputs", 32'({key_state, code_valid, code_len, code_bits,
                                            code_ovf, word_gap, fifo_ovf}), 32'(0));
        tick(2);
        rst_n = 1'b1;
        tick(40);
        check("final_valid", 32'(code_valid), 32'(0));
        check("scoreboard_empty", 32'(exp_q.size()), 32'(0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
